interrupt_ctrl: RTL and testbench

INTERRUPT_CTRL -- requirements
Module: interrupt_ctrl

---
 rtl/interrupt_ctrl.sv | 155 +++++++++++++++
 tb/tb_interrupt_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_ctrl.sv
// Interrupt controller: IF/IE registers, IME with delayed EI, and an IDLE/REQ/SERVICE dispatch FSM.
// Latency: irq_in reaches IF in 1 cycle; a qualifying instr_boundary raises int_req 1 cycle later.
// Backpressure: int_req holds until int_ack (or cancellation); int_active holds until int_done.
module interrupt_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  irq_in,
    input  logic [15:0] addr,
    input  logic [7:0]  data_in,
    input  logic        write_en,
    output logic [7:0]  data_out,
    input  logic        instr_boundary,
    input  logic        ei_req,
    input  logic        di_req,
    input  logic        reti_req,
    input  logic        int_ack,
    input  logic        int_done,
    output logic        int_req,
    output logic [2:0]  int_pc_out,
    output logic        int_active,
    output logic        wake
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam logic [15:0] ADDR_IF = 16'hFF0F;
    localparam logic [15:0] ADDR_IE = 16'hFFFF;

    state_t      state;
    logic [4:0]  if_q;
    logic [7:0]  ie_q;
    logic        ime;
    logic        ei_pending;

    logic [4:0]  pending;
    logic [2:0]  top_idx;
    logic [4:0]  if_next;
    logic        ack_take;
    logic        take_req;
    logic        wr_if;
    logic        wr_ie;

    assign pending  = ie_q[4:0] & if_q;
    assign wake     = |pending;
    assign wr_if    = write_en && (addr == ADDR_IF);
    assign wr_ie    = write_en && (addr == ADDR_IE);
    assign ack_take = (state == REQ) && int_ack && (pending != 5'd0);

    // A pending EI counts as enabled at the boundary that promotes it, so the
    // instruction after EI completes and the dispatch follows that boundary.
    assign take_req = (state == IDLE) && instr_boundary && (ime || ei_pending)
                      && (pending != 5'd0);

    // Priority encoder: lowest set pending bit wins.
    always_comb begin
        top_idx = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (pending[i]) top_idx = 3'(i);
        end
    end

    // IF next value: CPU write, then acked-bit clear, then new requests (set wins).
    always_comb begin
        if_next = if_q;
        if (wr_if) if_next = data_in[4:0];
        if (ack_take) if_next = if_next & ~(5'd1 << top_idx);
        if_next = if_next | irq_in;
    end

    // Register read mux; unused IF bits read as ones.
    always_comb begin
        data_out = 8'h00;
        if (addr == ADDR_IF) data_out = {3'b111, if_q};
        else if (addr == ADDR_IE) data_out = ie_q;
    end

    // IF/IE registers and the master enable with its one-instruction EI delay.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            if_q       <= 5'd0;
            ie_q       <= 8'h00;
            ime        <= 1'b0;
            ei_pending <= 1'b0;
        end else begin
            logic ime_n;
            logic eip_n;
            ime_n = ime;
            eip_n = ei_pending;
            if (instr_boundary && ei_pending) begin
                ime_n = 1'b1;
                eip_n = 1'b0;
            end
            if (ei_req)   eip_n = 1'b1;
            if (reti_req) ime_n = 1'b1;
            if (di_req) begin
                ime_n = 1'b0;
                eip_n = 1'b0;
            end
            if (ack_take) begin
                ime_n = 1'b0;
                eip_n = 1'b0;
            end
            if_q       <= if_next;
            ime        <= ime_n;
            ei_pending <= eip_n;
            if (wr_ie) ie_q <= data_in;
        end
    end

    // Dispatch FSM with registered handshake outputs and latched vector.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            int_req    <= 1'b0;
            int_active <= 1'b0;
            int_pc_out <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (take_req) begin
                        state   <= REQ;
                        int_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (ack_take) begin
                        state      <= SERVICE;
                        int_req    <= 1'b0;
                        int_active <= 1'b1;
                        int_pc_out <= top_idx;
                    end else if (pending == 5'd0) begin
                        state   <= IDLE;
                        int_req <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (int_done) begin
                        state      <= IDLE;
                        int_active <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    int_req    <= 1'b0;
                    int_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Bench for interrupt_ctrl: directed scenarios with literal expectations plus
// a randomized run compared every cycle against a behavioural model.
// The model steps on each clock edge from the same inputs the DUT sees.
module tb_interrupt_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  irq_in = '0;
    logic [15:0] addr = '0;
    logic [7:0]  data_in = '0;
    logic        write_en = 1'b0;
    logic [7:0]  data_out;
    logic        instr_boundary = 1'b0;
    logic        ei_req = 1'b0;
    logic        di_req = 1'b0;
    logic        reti_req = 1'b0;
    logic        int_ack = 1'b0;
    logic        int_done = 1'b0;
    logic        int_req;
    logic [2:0]  int_pc_out;
    logic        int_active;
    logic        wake;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    interrupt_ctrl dut (
        .clock(clock), .reset(reset), .irq_in(irq_in), .addr(addr),
        .data_in(data_in), .write_en(write_en), .data_out(data_out),
        .instr_boundary(instr_boundary), .ei_req(ei_req), .di_req(di_req),
        .reti_req(reti_req), .int_ack(int_ack), .int_done(int_done),
        .int_req(int_req), .int_pc_out(int_pc_out), .int_active(int_active),
        .wake(wake)
    );

    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [4:0] ifr;
        logic [7:0] ie;
        logic       ime;
        logic       eip;
        logic       req;
        logic       serv;
        logic [2:0] vec;
    } mdl_t;

    mdl_t m;

    function automatic int lowest(input logic [4:0] p);
        for (int i = 0; i < 5; i++) if (p[i]) return i;
        return 0;
    endfunction

    function automatic logic [7:0] rd(input mdl_t s, input logic [15:0] a);
        if (a == 16'hFF0F) return {3'b111, s.ifr};
        if (a == 16'hFFFF) return s.ie;
        return 8'h00;
    endfunction

    function automatic mdl_t step(input mdl_t s, input logic [4:0] irq,
                                  input logic [15:0] a, input logic [7:0] d,
                                  input logic we, input logic ib, input logic ei,
                                  input logic di, input logic reti,
                                  input logic ack, input logic done);
        mdl_t n = s;
        logic [4:0] pend = s.ie[4:0] & s.ifr;
        bit acked = s.req && ack && (pend != 0);
        if (we && a == 16'hFF0F) n.ifr = d[4:0];
        if (acked) n.ifr = n.ifr & ~(5'd1 << lowest(pend));
        n.ifr = n.ifr | irq;
        if (we && a == 16'hFFFF) n.ie = d;
        if (ib && s.eip) begin n.ime = 1; n.eip = 0; end
        if (ei) n.eip = 1;
        if (reti) n.ime = 1;
        if (di) begin n.ime = 0; n.eip = 0; end
        if (acked) begin n.ime = 0; n.eip = 0; n.vec = 3'(lowest(pend)); end
        if (!s.req && !s.serv)
            n.req = ib && (s.ime || s.eip) && (pend != 0);
        else if (s.req) begin
            if (acked) begin n.req = 0; n.serv = 1; end
            else if (pend == 0) n.req = 0;
        end else if (done)
            n.serv = 0;
        return n;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) m <= '0;
        else m <= step(m, irq_in, addr, data_in, write_en, instr_boundary,
                       ei_req, di_req, reti_req, int_ack, int_done);
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (chk_en && !reset) begin
            checks += 5;
            if (int_req !== m.req) begin
                errors++; $display("FAIL cyc_int_req t=%0t got %b exp %b", $time, int_req, m.req);
            end
            if (int_active !== m.serv) begin
                errors++; $display("FAIL cyc_int_active t=%0t got %b exp %b", $time, int_active, m.serv);
            end
            if (int_pc_out !== m.vec) begin
                errors++; $display("FAIL cyc_int_pc_out t=%0t got %0d exp %0d", $time, int_pc_out, m.vec);
            end
            if (wake !== |(m.ie[4:0] & m.ifr)) begin
                errors++; $display("FAIL cyc_wake t=%0t got %b exp %b", $time, wake, |(m.ie[4:0] & m.ifr));
            end
            if (data_out !== rd(m, addr)) begin
                errors++; $display("FAIL cyc_data_out t=%0t addr %h got %h exp %h", $time, addr, data_out, rd(m, addr));
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %h exp %h", name, $time, act, exp);
        end
    endtask

    // Consume one clock edge with the currently driven inputs, then drop pulses.
    task automatic cyc();
        @(posedge clock);
        #1;
        irq_in = '0; write_en = 0; instr_boundary = 0;
        ei_req = 0; di_req = 0; reti_req = 0; int_ack = 0; int_done = 0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        addr = a; data_in = d; write_en = 1;
        cyc();
    endtask

    task automatic rd_chk(input string name, input logic [15:0] a, input logic [7:0] exp);
        addr = a;
        #1;
        chk(name, 16'(data_out), 16'(exp));
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clock);
        #1;
        rd_chk("rst_if", 16'hFF0F, 8'hE0);
        rd_chk("rst_ie", 16'hFFFF, 8'h00);
        chk("rst_int_req", 16'(int_req), 16'd0);
        chk("rst_wake", 16'(wake), 16'd0);
        chk("rst_active", 16'(int_active), 16'd0);
        chk("rst_pc", 16'(int_pc_out), 16'd0);
        @(posedge clock);
        #1;
        reset = 0;
        chk_en = 1;

        // VBlank dispatch with Timer also pending
        wr(16'hFFFF, 8'h05);
        reti_req = 1; instr_boundary = 1; cyc();
        chk("reti_no_req", 16'(int_req), 16'd0);
        irq_in = 5'h05; cyc();
        rd_chk("if_after_irq", 16'hFF0F, 8'hE5);
        instr_boundary = 1; cyc();
        chk("vb_int_req", 16'(int_req), 16'd1);
        int_ack = 1; cyc();
        chk("vb_pc", 16'(int_pc_out), 16'd0);
        chk("vb_active", 16'(int_active), 16'd1);
        chk("vb_req_drop", 16'(int_req), 16'd0);
        rd_chk("vb_if_cleared", 16'hFF0F, 8'hE4);
        int_done = 1; cyc();
        chk("vb_done", 16'(int_active), 16'd0);
        instr_boundary = 1; cyc();
        chk("ime_cleared", 16'(int_req), 16'd0);
        wr(16'hFF0F, 8'h00);

        // HALT wake without IME
        wr(16'hFFFF, 8'h10);
        irq_in = 5'h10; cyc();
        chk("wake_set", 16'(wake), 16'd1);
        for (int i = 0; i < 3; i++) begin
            instr_boundary = 1; cyc();
            chk("wake_no_req", 16'(int_req), 16'd0);
        end
        wr(16'hFF0F, 8'h00);
        chk("wake_clear", 16'(wake), 16'd0);

        // EI delay
        wr(16'hFFFF, 8'h04);
        wr(16'hFF0F, 8'h04);
        ei_req = 1; instr_boundary = 1; cyc();
        chk("ei_bnd_n", 16'(int_req), 16'd0);
        cyc();
        chk("ei_mid", 16'(int_req), 16'd0);
        instr_boundary = 1; cyc();
        chk("ei_bnd_n1", 16'(int_req), 16'd1);

        // Cancellation by IF write while requesting
        wr(16'hFF0F, 8'h00);
        cyc();
        chk("cancel_req", 16'(int_req), 16'd0);
        chk("cancel_pc", 16'(int_pc_out), 16'd0);
        int_ack = 1; cyc();
        chk("stray_ack", 16'(int_active), 16'd0);

        // Set beats ack-clear on the same bit; async reset in SERVICE
        wr(16'hFFFF, 8'h0C);
        wr(16'hFF0F, 8'h08);
        instr_boundary = 1; cyc();
        chk("ser_req", 16'(int_req), 16'd1);
        int_ack = 1; irq_in = 5'h08; cyc();
        chk("ser_pc", 16'(int_pc_out), 16'd3);
        chk("ser_active", 16'(int_active), 16'd1);
        rd_chk("set_wins", 16'hFF0F, 8'hE8);
        irq_in = 5'h02; cyc();
        rd_chk("irq_in_service", 16'hFF0F, 8'hEA);
        chk("ser_hold", 16'(int_active), 16'd1);
        #2;
        reset = 1;
        #1;
        chk("async_active", 16'(int_active), 16'd0);
        chk("async_pc", 16'(int_pc_out), 16'd0);
        rd_chk("async_if", 16'hFF0F, 8'hE0);
        @(posedge clock);
        #1;
        reset = 0;

        // No request after reset until IME is set
        wr(16'hFFFF, 8'h01);
        wr(16'hFF0F, 8'h01);
        for (int i = 0; i < 3; i++) begin
            instr_boundary = 1; cyc();
            chk("post_rst_no_req", 16'(int_req), 16'd0);
        end

        // Randomized run against the model
        for (int c = 0; c < 3000; c++) begin
            int r;
            irq_in = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            r = $urandom_range(0, 4);
            addr = (r == 4) ? 16'($urandom) : (r[0] ? 16'hFFFF : 16'hFF0F);
            data_in = 8'($urandom);
            write_en = ($urandom_range(0, 9) == 0);
            instr_boundary = ($urandom_range(0, 2) == 0);
            ei_req = instr_boundary && ($urandom_range(0, 5) == 0);
            di_req = instr_boundary && ($urandom_range(0, 9) == 0);
            reti_req = instr_boundary && ($urandom_range(0, 5) == 0);
            int_ack = ($urandom_range(0, 2) == 0);
            int_done = ($urandom_range(0, 2) == 0);
            if (c % 1000 == 500) begin
                #2;
                reset = 1;
                @(posedge clock);
                #1;
                reset = 0;
            end else begin
                @(posedge clock);
                #1;
            end
        end
        cyc();
        @(negedge clock);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
